// File: rtl/mcu_fsm.sv
// mcu_fsm -- multicycle control FSM for a small MIPS-subset core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables and selects,
// pulses instr_done on the last cycle of each retired instruction and counts
// retired instructions.
// Optional feature macro: MCU_EXC_EN -- adds the EXC state with the exc and
// exc_cause outputs (illegal instruction, bus timeout). Without it, undecoded
// instructions retire as NOPs and memory waits are unbounded.
module mcu_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PcWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUsrc,
    output logic             ALUsrcA,
    output logic [1:0]       PcSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ExtOp,
    output logic [3:0]       ALUctr,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
`ifdef MCU_EXC_EN
    ,
    output logic             exc,
    output logic [1:0]       exc_cause
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        EXC    = 3'd5
    } stateT;

    // Instruction class derived from op/funct; iBad covers everything undecoded.
    typedef enum logic [3:0] {
        iAddu, iSubu, iSlt, iJr, iOri, iLw, iSw, iBeq,
        iLui, iAddi, iAddiu, iJ, iJal, iBad
    } instrT;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    stateT            stateQ;
    stateT            stateD;
    instrT            instr;
    logic             isRtype;
    logic [7:0]       waitCnt;
    logic [CNT_W-1:0] instrCnt;

`ifdef MCU_EXC_EN
    logic [1:0]       causeQ;
    logic [1:0]       causeD;
    logic             waitLast;

    // The current mem_ready-low cycle is the one that brings the count to MEM_TIMEOUT.
    assign waitLast  = (waitCnt >= (TIMEOUT - 8'd1));
    assign exc       = (stateQ == EXC);
    assign exc_cause = causeQ;
`endif

    assign state     = stateQ;
    assign instr_cnt = instrCnt;
    assign isRtype   = (op == 6'h00);

    // Classify the instruction register contents into a decoded instruction class.
    always_comb begin
        instr = iBad;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   instr = iAddu;
                    6'h23:   instr = iSubu;
                    6'h2A:   instr = iSlt;
                    6'h08:   instr = iJr;
                    default: instr = iBad;
                endcase
            end
            6'h0D:   instr = iOri;
            6'h23:   instr = iLw;
            6'h2B:   instr = iSw;
            6'h04:   instr = iBeq;
            6'h0F:   instr = iLui;
            6'h08:   instr = iAddi;
            6'h09:   instr = iAddiu;
            6'h02:   instr = iJ;
            6'h03:   instr = iJal;
            default: instr = iBad;
        endcase
    end

    // Next-state and output decode; everything is forced low while rst_n is low.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        stateD     = stateQ;
        PcWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUsrc     = 1'b0;
        ALUsrcA    = 1'b0;
        PcSrc      = 2'd0;
        RegDst     = 2'd0;
        MemtoReg   = 2'd0;
        ExtOp      = 2'd0;
        ALUctr     = 4'b0000;
        instr_done = 1'b0;
`ifdef MCU_EXC_EN
        causeD     = 2'd0;
`endif

        case (stateQ)
            FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PcWrite = 1'b1;
                    PcSrc   = 2'd0;
                    stateD  = DECODE;
                end
`ifdef MCU_EXC_EN
                else if (waitLast) begin
                    stateD = EXC;
                    causeD = 2'd2;
                end
`endif
            end

            DECODE: begin
                case (instr)
                    iJ: begin
                        PcWrite    = 1'b1;
                        PcSrc      = 2'd2;
                        instr_done = 1'b1;
                        stateD     = FETCH;
                    end
                    iJal: begin
                        PcWrite    = 1'b1;
                        PcSrc      = 2'd2;
                        RegWrite   = 1'b1;
                        RegDst     = 2'd2;
                        MemtoReg   = 2'd2;
                        instr_done = 1'b1;
                        stateD     = FETCH;
                    end
                    iJr: begin
                        PcWrite    = 1'b1;
                        PcSrc      = 2'd3;
                        instr_done = 1'b1;
                        stateD     = FETCH;
                    end
                    iBad: begin
`ifdef MCU_EXC_EN
                        stateD = EXC;
                        causeD = 2'd1;
`else
                        // Retire as a NOP: PC was already advanced in FETCH.
                        instr_done = 1'b1;
                        stateD     = FETCH;
`endif
                    end
                    default: stateD = EXEC;
                endcase
            end

            EXEC: begin
                case (instr)
                    iAddu:  ALUctr = 4'b1000;
                    iSubu:  ALUctr = 4'b1010;
                    iSlt:   ALUctr = 4'b0111;
                    iBeq:   ALUctr = 4'b1010;
                    iOri: begin
                        ALUctr = 4'b0001;
                        ALUsrc = 1'b1;
                        ExtOp  = 2'd0;
                    end
                    iLw, iSw, iAddi: begin
                        ALUctr = 4'b0010;
                        ALUsrc = 1'b1;
                        ExtOp  = 2'd2;
                    end
                    iAddiu: begin
                        ALUctr = 4'b1000;
                        ALUsrc = 1'b1;
                        ExtOp  = 2'd2;
                    end
                    iLui: begin
                        ALUctr = 4'b0001;
                        ALUsrc = 1'b1;
                        ExtOp  = 2'd1;
                    end
                    default: ALUctr = 4'b0000;
                endcase

                case (instr)
                    iBeq: begin
                        PcWrite    = zero;
                        PcSrc      = 2'd1;
                        instr_done = 1'b1;
                        stateD     = FETCH;
                    end
                    iLw, iSw: stateD = MEM;
                    default:  stateD = WB;
                endcase
            end

            MEM: begin
                MemRead  = (instr == iLw);
                MemWrite = (instr == iSw);
                if (mem_ready) begin
                    if (instr == iSw) begin
                        instr_done = 1'b1;
                        stateD     = FETCH;
                    end else begin
                        stateD = WB;
                    end
                end
`ifdef MCU_EXC_EN
                else if (waitLast) begin
                    stateD = EXC;
                    causeD = 2'd2;
                end
`endif
            end

            WB: begin
                RegWrite   = 1'b1;
                RegDst     = {1'b0, isRtype};
                case (instr)
                    iLw:     MemtoReg = 2'd1;
                    iLui:    MemtoReg = 2'd3;
                    default: MemtoReg = 2'd0;
                endcase
                instr_done = 1'b1;
                stateD     = FETCH;
            end

`ifdef MCU_EXC_EN
            EXC: begin
                // Vector address comes from an external mux on the jump path.
                PcWrite = 1'b1;
                PcSrc   = 2'd2;
                stateD  = FETCH;
            end
`endif

            default: stateD = FETCH;
        endcase

        if (!rst_n) begin
            PcWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            ALUsrc     = 1'b0;
            PcSrc      = 2'd0;
            RegDst     = 2'd0;
            MemtoReg   = 2'd0;
            ExtOp      = 2'd0;
            ALUctr     = 4'b0000;
            instr_done = 1'b0;
        end
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            stateQ <= FETCH;
        end else begin
            stateQ <= stateD;
        end
    end

    // Memory wait counter: cleared on entry to FETCH/MEM, counts mem_ready-low cycles, saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waitCnt <= 8'd0;
        end else if ((stateD != stateQ) && ((stateD == FETCH) || (stateD == MEM))) begin
            waitCnt <= 8'd0;
        end else if (((stateQ == FETCH) || (stateQ == MEM)) && !mem_ready && (waitCnt != TIMEOUT)) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instrCnt <= '0;
        end else if (instr_done) begin
            instrCnt <= instrCnt + 1'b1;
        end
    end

`ifdef MCU_EXC_EN
    // Exception cause: loaded on the transition into EXC, cleared on the way out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            causeQ <= 2'd0;
        end else begin
            causeQ <= causeD;
        end
    end
`endif

endmodule

// File: tb/tb_mcu_fsm.sv
// tb_mcu_fsm -- directed self-checking bench for mcu_fsm.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
// Built with MCU_EXC_EN defined, the exception paths are exercised instead of the NOP path.
module tb_mcu_fsm;

    localparam int CW  = 4;
    localparam int TMO = 15;

    logic          clk;
    logic          rst_n;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          mem_ready;
    logic          PcWrite;
    logic          IRWrite;
    logic          RegWrite;
    logic          MemRead;
    logic          MemWrite;
    logic          ALUsrc;
    logic          ALUsrcA;
    logic [1:0]    PcSrc;
    logic [1:0]    RegDst;
    logic [1:0]    MemtoReg;
    logic [1:0]    ExtOp;
    logic [3:0]    ALUctr;
    logic [2:0]    state;
    logic          instr_done;
    logic [CW-1:0] instr_cnt;
`ifdef MCU_EXC_EN
    logic          exc;
    logic [1:0]    exc_cause;
`endif

    int            checks;
    int            errors;
    logic [CW-1:0] expCnt;

    mcu_fsm #(
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PcWrite   (PcWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUsrc    (ALUsrc),
        .ALUsrcA   (ALUsrcA),
        .PcSrc     (PcSrc),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .ExtOp     (ExtOp),
        .ALUctr    (ALUctr),
        .state     (state),
        .instr_done(instr_done),
        .instr_cnt (instr_cnt)
`ifdef MCU_EXC_EN
        ,
        .exc       (exc),
        .exc_cause (exc_cause)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    // Move to 1 unit after the next rising edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction with mem_ready high until instr_done; bounded by a cycle budget.
    task automatic runInstr(input logic [5:0] o, input logic [5:0] f, output int cycles, output bit done);
        op = o; funct = f; mem_ready = 1'b1; cycles = 0; done = 1'b0;
        while (!done && cycles < 40) begin
            #1;
            cycles++;
            done = (instr_done === 1'b1);
            adv();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 6'h00; funct = 6'h21; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (instr_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", instr_cnt); end
        checks++;
        if ({MemRead, IRWrite, PcWrite, instr_done} !== 4'b0000)
            begin errors++; $display("FAIL reset_enables: got %b expected 0000", {MemRead, IRWrite, PcWrite, instr_done}); end
`ifdef MCU_EXC_EN
        checks++;
        if ({exc, exc_cause} !== 3'b000) begin errors++; $display("FAIL reset_exc: got %b expected 000", {exc, exc_cause}); end
`endif
        adv();
        rst_n = 1'b1;
        expCnt = '0;
    endtask

    task automatic test_addu();
        op = 6'h00; funct = 6'h21; mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, MemRead, IRWrite, PcWrite, PcSrc} !== {3'd0, 1'b1, 1'b1, 1'b1, 2'd0})
            begin errors++; $display("FAIL addu_fetch: got %b expected 000_1_1_1_00", {state, MemRead, IRWrite, PcWrite, PcSrc}); end
        adv(); #1;
        checks++;
        if ({state, instr_done} !== {3'd1, 1'b0}) begin errors++; $display("FAIL addu_decode: got %b expected 0010", {state, instr_done}); end
        adv(); #1;
        checks++;
        if ({state, ALUctr, ALUsrc, ALUsrcA} !== {3'd2, 4'b1000, 1'b0, 1'b0})
            begin errors++; $display("FAIL addu_exec: got %b expected 010_1000_0_0", {state, ALUctr, ALUsrc, ALUsrcA}); end
        adv(); #1;
        checks++;
        if ({state, RegWrite, RegDst, MemtoReg, instr_done} !== {3'd4, 1'b1, 2'd1, 2'd0, 1'b1})
            begin errors++; $display("FAIL addu_wb: got %b expected 100_1_01_00_1", {state, RegWrite, RegDst, MemtoReg, instr_done}); end
        adv();
        expCnt++;
        checks++;
        if ({state, instr_cnt} !== {3'd0, expCnt}) begin errors++; $display("FAIL addu_cnt: got %0d/%0d expected 0/%0d", state, instr_cnt, expCnt); end
    endtask

    typedef struct {
        logic [5:0] o;
        logic [5:0] f;
        logic       chkAlu;
        logic [3:0] alu;
        logic       src;
        logic [1:0] ext;
        logic [1:0] m2r;
        logic [1:0] dst;
    } aluVecT;

    task automatic test_alu_ops();
        aluVecT v [6] = '{
            '{6'h00, 6'h23, 1'b1, 4'b1010, 1'b0, 2'd0, 2'd0, 2'd1},
            '{6'h00, 6'h2A, 1'b1, 4'b0111, 1'b0, 2'd0, 2'd0, 2'd1},
            '{6'h0D, 6'h00, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0, 2'd0},
            '{6'h08, 6'h00, 1'b1, 4'b0010, 1'b1, 2'd2, 2'd0, 2'd0},
            '{6'h09, 6'h00, 1'b1, 4'b1000, 1'b1, 2'd2, 2'd0, 2'd0},
            '{6'h0F, 6'h00, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd3, 2'd0}
        };
        for (int i = 0; i < 6; i++) begin
            op = v[i].o; funct = v[i].f; mem_ready = 1'b1;
            #1;
            adv(); #1;
            checks++;
            if (state !== 3'd1) begin errors++; $display("FAIL alu%0d_decode: got %0d expected 1", i, state); end
            adv(); #1;
            checks++;
            if ({state, ALUsrc, ExtOp} !== {3'd2, v[i].src, v[i].ext})
                begin errors++; $display("FAIL alu%0d_exec: got %b expected %b", i, {state, ALUsrc, ExtOp}, {3'd2, v[i].src, v[i].ext}); end
            if (v[i].chkAlu) begin
                checks++;
                if (ALUctr !== v[i].alu) begin errors++; $display("FAIL alu%0d_ctr: got %b expected %b", i, ALUctr, v[i].alu); end
            end
            adv(); #1;
            checks++;
            if ({state, RegWrite, RegDst, MemtoReg, instr_done} !== {3'd4, 1'b1, v[i].dst, v[i].m2r, 1'b1})
                begin errors++; $display("FAIL alu%0d_wb: got %b expected %b", i, {state, RegWrite, RegDst, MemtoReg, instr_done}, {3'd4, 1'b1, v[i].dst, v[i].m2r, 1'b1}); end
            adv();
            expCnt++;
            checks++;
            if (instr_cnt !== expCnt) begin errors++; $display("FAIL alu%0d_cnt: got %0d expected %0d", i, instr_cnt, expCnt); end
        end
    endtask

    task automatic test_lw_wait();
        logic [2:0] expState [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        op = 6'h23; funct = 6'h00;
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if ({state, instr_done} !== {expState[c], (c == 7)})
                begin errors++; $display("FAIL lw_cycle%0d: got state %0d done %b expected state %0d done %b", c, state, instr_done, expState[c], (c == 7)); end
            if (c == 3) begin
                checks++;
                if ({MemRead, MemWrite} !== 2'b10) begin errors++; $display("FAIL lw_memread: got %b expected 10", {MemRead, MemWrite}); end
            end
            if (c == 7) begin
                checks++;
                if ({RegWrite, RegDst, MemtoReg} !== {1'b1, 2'd0, 2'd1})
                    begin errors++; $display("FAIL lw_wb: got %b expected 1_00_01", {RegWrite, RegDst, MemtoReg}); end
            end
            adv();
        end
        expCnt++;
        checks++;
        if (instr_cnt !== expCnt) begin errors++; $display("FAIL lw_cnt: got %0d expected %0d", instr_cnt, expCnt); end
    endtask

    task automatic test_sw();
        logic [2:0] expState [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
        op = 6'h2B; funct = 6'h00;
        for (int c = 0; c < 6; c++) begin
            mem_ready = (c < 2) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if ({state, instr_done} !== {expState[c], (c == 5)})
                begin errors++; $display("FAIL sw_cycle%0d: got state %0d done %b expected state %0d done %b", c, state, instr_done, expState[c], (c == 5)); end
            checks++;
            if ((MemWrite & RegWrite) !== 1'b0) begin errors++; $display("FAIL sw_excl%0d: got MemWrite&RegWrite=%b expected 0", c, MemWrite & RegWrite); end
            if (c == 0) begin
                checks++;
                if ({MemRead, IRWrite, PcWrite} !== 3'b100) begin errors++; $display("FAIL sw_fetch_wait: got %b expected 100", {MemRead, IRWrite, PcWrite}); end
            end
            if (c == 4) begin
                checks++;
                if ({ALUsrc, ExtOp} !== 3'b110) begin errors++; $display("FAIL sw_exec: got %b expected 110", {ALUsrc, ExtOp}); end
            end
            if (c == 5) begin
                checks++;
                if ({MemWrite, MemRead, RegWrite} !== 3'b100) begin errors++; $display("FAIL sw_mem: got %b expected 100", {MemWrite, MemRead, RegWrite}); end
            end
            adv();
        end
        expCnt++;
        checks++;
        if (instr_cnt !== expCnt) begin errors++; $display("FAIL sw_cnt: got %0d expected %0d", instr_cnt, expCnt); end
    endtask

    task automatic test_beq();
        for (int z = 0; z < 2; z++) begin
            op = 6'h04; funct = 6'h00; mem_ready = 1'b1; zero = z[0];
            #1;
            adv(); #1;
            checks++;
            if ({state, instr_done} !== {3'd1, 1'b0}) begin errors++; $display("FAIL beq%0d_decode: got %b expected 0010", z, {state, instr_done}); end
            adv(); #1;
            checks++;
            if ({state, PcWrite, PcSrc, instr_done, RegWrite} !== {3'd2, z[0], 2'd1, 1'b1, 1'b0})
                begin errors++; $display("FAIL beq%0d_exec: got %b expected %b", z, {state, PcWrite, PcSrc, instr_done, RegWrite}, {3'd2, z[0], 2'd1, 1'b1, 1'b0}); end
            adv();
            expCnt++;
            checks++;
            if ({state, instr_cnt} !== {3'd0, expCnt}) begin errors++; $display("FAIL beq%0d_end: got %0d/%0d expected 0/%0d", z, state, instr_cnt, expCnt); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        // op, funct, PcSrc, RegWrite, RegDst, MemtoReg
        logic [13:0] vec [3] = '{
            {6'h02, 6'h00, 2'd2},
            {6'h03, 6'h00, 2'd2},
            {6'h00, 6'h08, 2'd3}
        };
        logic [4:0] wr [3] = '{5'b0_00_00, 5'b1_10_10, 5'b0_00_00};
        for (int i = 0; i < 3; i++) begin
            op = vec[i][13:8]; funct = vec[i][7:2]; mem_ready = 1'b1;
            #1;
            adv(); #1;
            checks++;
            if ({state, PcWrite, PcSrc, instr_done} !== {3'd1, 1'b1, vec[i][1:0], 1'b1})
                begin errors++; $display("FAIL jump%0d_pc: got %b expected %b", i, {state, PcWrite, PcSrc, instr_done}, {3'd1, 1'b1, vec[i][1:0], 1'b1}); end
            checks++;
            if ({RegWrite, RegDst, MemtoReg} !== wr[i])
                begin errors++; $display("FAIL jump%0d_wr: got %b expected %b", i, {RegWrite, RegDst, MemtoReg}, wr[i]); end
            adv();
            expCnt++;
            checks++;
            if ({state, instr_cnt} !== {3'd0, expCnt}) begin errors++; $display("FAIL jump%0d_end: got %0d/%0d expected 0/%0d", i, state, instr_cnt, expCnt); end
        end
    endtask

    task automatic test_undecoded();
`ifdef MCU_EXC_EN
        op = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
        #1;
        adv(); #1;
        checks++;
        if ({state, instr_done, exc} !== {3'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL illegal_decode: got %b expected 00100", {state, instr_done, exc}); end
        adv(); #1;
        checks++;
        if ({state, exc, exc_cause, PcWrite, PcSrc, instr_done} !== {3'd5, 1'b1, 2'd1, 1'b1, 2'd2, 1'b0})
            begin errors++; $display("FAIL illegal_exc: got %b expected 101_1_01_1_10_0", {state, exc, exc_cause, PcWrite, PcSrc, instr_done}); end
        adv(); #1;
        checks++;
        if ({state, exc, instr_cnt} !== {3'd0, 1'b0, expCnt}) begin errors++; $display("FAIL illegal_after: got %0d/%b/%0d expected 0/0/%0d", state, exc, instr_cnt, expCnt); end
        op = 6'h00; funct = 6'h21; mem_ready = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            #1;
            if (c == TMO - 1) begin
                checks++;
                if ({state, IRWrite, exc} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL timeout_wait: got %b expected 00000", {state, IRWrite, exc}); end
            end
            adv();
        end
        #1;
        checks++;
        if ({state, exc, exc_cause, instr_done} !== {3'd5, 1'b1, 2'd2, 1'b0})
            begin errors++; $display("FAIL timeout_exc: got %b expected 101_1_10_0", {state, exc, exc_cause, instr_done}); end
        mem_ready = 1'b1;
        adv();
        checks++;
        if ({state, instr_cnt} !== {3'd0, expCnt}) begin errors++; $display("FAIL timeout_after: got %0d/%0d expected 0/%0d", state, instr_cnt, expCnt); end
`else
        op = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
        #1;
        adv(); #1;
        checks++;
        if ({state, instr_done, PcWrite, RegWrite} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL nop_decode: got %b expected 001100", {state, instr_done, PcWrite, RegWrite}); end
        adv();
        expCnt++;
        checks++;
        if ({state, instr_cnt} !== {3'd0, expCnt}) begin errors++; $display("FAIL nop_cnt: got %0d/%0d expected 0/%0d", state, instr_cnt, expCnt); end
        op = 6'h00; funct = 6'h21; mem_ready = 1'b0;
        repeat (TMO + 5) adv();
        #1;
        checks++;
        if ({state, IRWrite, MemRead} !== {3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL long_wait: got %b expected 00001", {state, IRWrite, MemRead}); end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (IRWrite !== 1'b1) begin errors++; $display("FAIL long_wait_ready: got %b expected 1", IRWrite); end
        repeat (4) adv();
        expCnt++;
        checks++;
        if ({state, instr_cnt} !== {3'd0, expCnt}) begin errors++; $display("FAIL long_wait_cnt: got %0d/%0d expected 0/%0d", state, instr_cnt, expCnt); end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        int total;
        bit done;
        logic [CW-1:0] startCnt;
        runInstr(6'h00, 6'h21, cyc, done);
        checks++;
        if ({done, cyc} !== {1'b1, 32'd4}) begin errors++; $display("FAIL b2b_addu: got done %b cycles %0d expected done 1 cycles 4", done, cyc); end
        runInstr(6'h23, 6'h00, cyc, done);
        checks++;
        if ({done, cyc} !== {1'b1, 32'd5}) begin errors++; $display("FAIL b2b_lw: got done %b cycles %0d expected done 1 cycles 5", done, cyc); end
        runInstr(6'h2B, 6'h00, cyc, done);
        checks++;
        if ({done, cyc} !== {1'b1, 32'd4}) begin errors++; $display("FAIL b2b_sw: got done %b cycles %0d expected done 1 cycles 4", done, cyc); end
        expCnt = expCnt + 3;
        checks++;
        if (instr_cnt !== expCnt) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", instr_cnt, expCnt); end
        // Sixteen jumps take the 4-bit counter once all the way around.
        startCnt = expCnt;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            runInstr(6'h02, 6'h00, cyc, done);
            total += cyc;
        end
        checks++;
        if (total !== 32) begin errors++; $display("FAIL b2b_jumps: got %0d cycles expected 32", total); end
        checks++;
        if (instr_cnt !== startCnt) begin errors++; $display("FAIL cnt_wrap: got %0d expected %0d", instr_cnt, startCnt); end
    endtask

    task automatic test_reset_mid();
        op = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
        #1;
        adv();
        adv();
        adv();
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, MemWrite} !== {3'd3, 1'b1}) begin errors++; $display("FAIL rstmid_mem: got %b expected 0111", {state, MemWrite}); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({MemWrite, instr_done, MemRead, RegWrite} !== 4'b0000)
            begin errors++; $display("FAIL rstmid_force: got %b expected 0000", {MemWrite, instr_done, MemRead, RegWrite}); end
        adv();
        checks++;
        if ({state, instr_cnt} !== {3'd0, {CW{1'b0}}}) begin errors++; $display("FAIL rstmid_after: got %0d/%0d expected 0/0", state, instr_cnt); end
        expCnt = '0;
        rst_n = 1'b1;
        mem_ready = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expCnt = '0;
        test_reset();
        test_addu();
        test_alu_ops();
        test_lw_wait();
        test_sw();
        test_beq();
        test_jumps();
        test_undecoded();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
